// File: rtl/interrupt_controller.sv
// Prioritised edge-triggered interrupt controller feeding the status register.
// Define INT_MASK_EN to add a writable per-source mask register.
module interrupt_controller #(
    parameter int unsigned WORD = 16,
    parameter int unsigned PLVLS = 8,
    parameter int unsigned SOURCES = 8,
    parameter logic [WORD-1:0] VECBASE = 16'hFFC0,
    localparam int unsigned PRIVWIDTH = $clog2(PLVLS),
    localparam int unsigned IDWIDTH = $clog2(SOURCES)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [SOURCES-1:0]           irq_i,
    input  logic [SOURCES*PRIVWIDTH-1:0] srcPriv_i,
    input  logic                         ie_i,
    input  logic [PRIVWIDTH-1:0]         currPriv_i,
    input  logic                         intAck_i,
`ifdef INT_MASK_EN
    input  logic                         maskWr_i,
    input  logic [SOURCES-1:0]           mask_i,
`endif
    output logic                         intReq_o,
    output logic [IDWIDTH-1:0]           irqId_o,
    output logic [WORD-1:0]              vector_o,
    output logic                         setPriv_o,
    output logic [PRIVWIDTH-1:0]         priv_o,
    output logic                         clrSlp_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ENTER = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SOURCES-1:0]   irq_prev;
    logic [SOURCES-1:0]   pending_q;
    logic [SOURCES-1:0]   rise;
    logic [SOURCES-1:0]   clr_vec;
    logic [SOURCES-1:0]   mask;
    logic [SOURCES-1:0]   qual;
    logic [PRIVWIDTH-1:0] src_prio [SOURCES];

    logic                 sel_any;
    logic [IDWIDTH-1:0]   sel_id;
    logic [PRIVWIDTH-1:0] sel_prio;
    logic [WORD-1:0]      vec_off;

    logic                 load;
    logic                 ack_clr;

    logic [IDWIDTH-1:0]   id_q;
    logic [WORD-1:0]      vec_q;
    logic [PRIVWIDTH-1:0] prio_q;

    // Held across reset so a line already high at release is not an edge.
    always_ff @(posedge clk_i) begin
        irq_prev <= irq_i;
    end

    assign rise = irq_i & ~irq_prev;

`ifdef INT_MASK_EN
    logic [SOURCES-1:0] mask_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q <= '1;
        end else if (maskWr_i) begin
            mask_q <= mask_i;
        end
    end

    assign mask = mask_q;
`else
    assign mask = '1;
`endif

    always_comb begin
        for (int k = 0; k < SOURCES; k++) begin
            src_prio[k] = srcPriv_i[k*PRIVWIDTH +: PRIVWIDTH];
            qual[k] = pending_q[k] & ie_i & mask[k]
                    & (src_prio[k] > currPriv_i);
        end
    end

    // Strict compare keeps the lowest index on equal priority.
    always_comb begin
        sel_any  = 1'b0;
        sel_id   = '0;
        sel_prio = '0;
        for (int k = 0; k < SOURCES; k++) begin
            if (qual[k] && (!sel_any || src_prio[k] > sel_prio)) begin
                sel_any  = 1'b1;
                sel_id   = IDWIDTH'(k);
                sel_prio = src_prio[k];
            end
        end
    end

    always_comb begin
        vec_off = '0;
        vec_off[IDWIDTH:0] = {sel_id, 1'b0};
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ack_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_any) begin
                    state_d = REQ;
                    load    = 1'b1;
                end
            end
            REQ: begin
                if (intAck_i) begin
                    state_d = ENTER;
                    ack_clr = 1'b1;
                end else if (!qual[id_q]) begin
                    state_d = IDLE;
                end
            end
            ENTER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign clr_vec = ack_clr ? (SOURCES'(1) << id_q) : '0;

    // A new edge in the clearing cycle keeps the bit set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_vec) | rise;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q   <= '0;
            vec_q  <= '0;
            prio_q <= '0;
        end else if (load) begin
            id_q   <= sel_id;
            vec_q  <= VECBASE + vec_off;
            prio_q <= sel_prio;
        end
    end

    assign intReq_o  = (state_q == REQ);
    assign setPriv_o = (state_q == ENTER);
    assign clrSlp_o  = (state_q == ENTER);
    assign irqId_o   = id_q;
    assign vector_o  = vec_q;
    assign priv_o    = prio_q;

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Prioritised, edge-triggered interrupt controller that sits directly upstream of the status register. It latches requests from up to SOURCES peripherals and qualifies them against the status register's interrupt enable and current privilege level. It handshakes one winner at a time with the control unit. On acceptance it issues the one-cycle privilege-change and clear-sleep strobes that the status register consumes (setPriv, priv, clrSlp), together with the handler vector address.

## Interface
- WORD, 16, datapath/vector width
- PLVLS, 8, number of privilege levels; PRIVWIDTH = $clog2(PLVLS)
- SOURCES, 8, number of interrupt sources; IDWIDTH = $clog2(SOURCES)
- VECBASE, 16'hFFC0, base address of the vector table
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, synchronous, active-high
- irq_i  in  SOURCES  request lines, rising-edge sensitive
- srcPriv_i  in  SOURCES*PRIVWIDTH  packed per-source priority; source k uses bits [k*PRIVWIDTH +: PRIVWIDTH]
- ie_i  in  1  interrupt enable from status register
- currPriv_i  in  PRIVWIDTH  current privilege from status register
- intAck_i  in  1  control unit accepts the pending request at an instruction boundary
- intReq_o  out  1  interrupt request to control unit
- irqId_o  out  IDWIDTH  selected source index
- vector_o  out  WORD  handler address = VECBASE + 2*irqId
- setPriv_o  out  1  one-cycle strobe to status register setPriv
- priv_o  out  PRIVWIDTH  new privilege (priority of the selected source)
- clrSlp_o  out  1  one-cycle strobe to status register clrSlp

## Operation
- Edge capture: irq_prev registers irq_i every cycle. During reset irq_prev loads irq_i, so a line held high across reset release is not an edge. pending[k] is set when irq_i[k] & ~irq_prev[k].
- Qualification: source k qualifies when pending[k], ie_i = 1, srcPriv[k] > currPriv_i, and it is not masked (see Configuration). A priority-0 source never qualifies.
- Selection: among qualifying sources, the highest srcPriv wins; ties go to the lowest index.
- FSM states:
  - IDLE: if any source qualifies, register the winner's id, vector and priority, then go to REQ.
  - REQ: intReq_o = 1. Id, vector and priv are frozen; a later, higher-priority edge does not preempt.
    - intAck_i = 1 → go to ENTER and clear pending[id].
    - intAck_i = 0 and the winner no longer qualifies (ie_i dropped or currPriv_i rose) → withdraw and return to IDLE. pending[id] stays set.
  - ENTER: setPriv_o = 1 and clrSlp_o = 1 for exactly one cycle, with priv_o = the frozen priority; then go to IDLE.
- intAck_i outside REQ is ignored.
- If a new edge on source id arrives in the same cycle its pending bit is cleared, set wins and pending stays 1.
- Vector arithmetic: VECBASE + {irqId, 1'b0}, truncated to WORD bits, with no overflow detection.

## Timing
- Reset values: state IDLE; pending 0; intReq_o 0, irqId_o 0, vector_o 0, priv_o 0, setPriv_o 0, clrSlp_o 0.
- Reset asserted in any state returns the FSM to IDLE on the next edge and drops every strobe, including an ENTER already in progress.
- Latency:
  - irq_i rising, sampled at edge k → pending set after edge k → intReq_o high after edge k+1.
  - intAck_i sampled at edge m → setPriv_o/clrSlp_o high in cycle m..m+1 → IDLE after m+1.
  - The next intReq_o is possible at the earliest after edge m+2.
- irqId_o, vector_o and priv_o are registered. They are stable from REQ entry through the end of ENTER and hold their last value in IDLE.
- setPriv_o, clrSlp_o and intReq_o are decoded from state only, with no combinational path from intAck_i.

## Configuration
- INT_MASK_EN defined:
  - Adds ports maskWr_i (in, 1) and mask_i (in, SOURCES).
  - A mask register, reset to all ones, loads mask_i on a cycle with maskWr_i = 1.
  - A source with mask bit 0 still latches pending but does not qualify. Unmasking it later allows it to be taken.
  - Masking the current winner while in REQ causes withdrawal, as for loss of qualification.
- INT_MASK_EN undefined: the ports and register are absent, and every source is always unmasked.

## Test plan
- Basic: currPriv_i=0, ie_i=1, srcPriv[3]=5; pulse irq_i[3] → intReq_o after 2 cycles, irqId_o=3, vector_o=16'hFFC6. Ack → a single-cycle setPriv_o=clrSlp_o=1 with priv_o=5, and pending[3] cleared.
- Priority/tie: edges on sources 1 (prio 4), 2 (prio 6) and 6 (prio 6) in the same cycle → served in the order 2, 6, 1, each with one full handshake.
- Qualification: currPriv_i=5 and an edge on a prio-5 source → no intReq_o. Raise the source to prio 6 → intReq_o. With ie_i=0 → no request, and the request appears once ie_i returns to 1.
- Withdrawal: in REQ, drop ie_i before ack → intReq_o falls next cycle with no strobes; raise ie_i → the same id is requested again.
- Reset: assert rst_i during ENTER with irq_i[0] held high → all outputs 0 next cycle; release → no request from the held line until a new rising edge.
- INT_MASK_EN: write mask=8'hFE, then an edge on source 0 → no request; write mask=8'hFF → request with irqId_o=0.
